// File: rtl/link_pkg.sv
// Shared constants and types for the serial sample link transmitter.
package link_pkg;

  localparam int unsigned LINK_WORD_W  = 16;
  localparam int unsigned LINK_SLOTS   = 17;
  localparam logic        LINK_PAD_BIT = 1'b0;

  typedef logic [4:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAD,
    ST_DATA
  } link_state_t;

endpackage

// File: rtl/link_tx_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at/after the pointer; the
// pointer advances past each grant.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [3:0]       grant_id
);

  logic [3:0] ptr;
  logic       found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (en && !found && req[j] && (j == (32'(ptr) + i) % N_REQ)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = 4'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 4'd1;
    end
  end

endmodule

// File: rtl/link_tx_sched.sv
// Link master: round-robin accept into a 1-deep holding register, then serialise
// 16-bit words MSB first with a derived sclk, pad slot and frame sync.
module link_tx_sched
  import link_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         i_req_vld,
  input  logic [16*N_REQ-1:0]      i_req_data,
  output logic [N_REQ-1:0]         o_req_rdy,
  output logic                     o_sclk,
  output logic                     o_fs,
  output logic                     o_sd,
  output logic                     o_busy,
  output logic [3:0]               o_cur_id
);

  localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam slot_t SLOT_LAST = slot_t'(LINK_SLOTS - 1);
  localparam slot_t SLOT_BIT0 = slot_t'(LINK_SLOTS - 2);

  link_state_t            state, state_nxt;
  logic [PH_W-1:0]        phase, phase_nxt;
  slot_t                  slot, slot_nxt;
  logic [LINK_WORD_W-1:0] shreg, shreg_nxt;
  logic                   sclk_nxt, sd_nxt, fs_nxt;
  logic [3:0]             cur_id_nxt;
  logic                   take;
  logic                   tick;

  logic                   hold_full;
  logic [LINK_WORD_W-1:0] hold_data;
  logic [3:0]             hold_id;
  logic [3:0]             rdy_id;
  logic [N_REQ-1:0]       grant;
  logic [3:0]             grant_id;
  logic                   arb_en;
  logic                   xfer;

  // rdy is registered, so arbitration pauses while a grant is outstanding
  assign arb_en = !hold_full && !(|o_req_rdy);
  assign xfer   = |(o_req_rdy & i_req_vld);
  assign tick   = (phase == PH_LAST);
  assign o_busy = (state != ST_IDLE) || hold_full;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (i_clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .req      (i_req_vld),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req_rdy <= '0;
      rdy_id    <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_id   <= '0;
    end else begin
      o_req_rdy <= grant;
      rdy_id    <= grant_id;
      if (xfer) begin
        hold_full <= 1'b1;
        hold_data <= i_req_data[LINK_WORD_W*rdy_id +: LINK_WORD_W];
        hold_id   <= rdy_id;
      end else if (take) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= '0;
      slot     <= '0;
      shreg    <= '0;
      o_sclk   <= 1'b1;
      o_sd     <= LINK_PAD_BIT;
      o_fs     <= 1'b0;
      o_cur_id <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      slot     <= slot_nxt;
      shreg    <= shreg_nxt;
      o_sclk   <= sclk_nxt;
      o_sd     <= sd_nxt;
      o_fs     <= fs_nxt;
      o_cur_id <= cur_id_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    slot_nxt   = slot;
    shreg_nxt  = shreg;
    sclk_nxt   = o_sclk;
    sd_nxt     = o_sd;
    fs_nxt     = o_fs;
    cur_id_nxt = o_cur_id;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        sclk_nxt  = 1'b1;
        sd_nxt    = LINK_PAD_BIT;
        fs_nxt    = 1'b0;
        phase_nxt = '0;
        slot_nxt  = '0;
        if (hold_full) begin
          take       = 1'b1;
          shreg_nxt  = hold_data;
          cur_id_nxt = hold_id;
          state_nxt  = ST_PAD;
        end
      end
      default: begin
        if (!tick) begin
          phase_nxt = phase + 1'b1;
        end else begin
          phase_nxt = '0;
          sclk_nxt  = ~o_sclk;
          // Data and fs only move on the rising half of each slot
          if (!o_sclk) begin
            if (state == ST_DATA && slot == SLOT_LAST) begin
              if (o_fs) begin
                take       = 1'b1;
                sd_nxt     = hold_data[LINK_WORD_W-1];
                shreg_nxt  = {hold_data[LINK_WORD_W-2:0], 1'b0};
                cur_id_nxt = hold_id;
                slot_nxt   = slot_t'(1);
                fs_nxt     = 1'b0;
              end else begin
                sd_nxt    = LINK_PAD_BIT;
                slot_nxt  = '0;
                state_nxt = ST_IDLE;
              end
            end else begin
              sd_nxt    = shreg[LINK_WORD_W-1];
              shreg_nxt = {shreg[LINK_WORD_W-2:0], 1'b0};
              slot_nxt  = slot + slot_t'(1);
              state_nxt = ST_DATA;
              if (slot == SLOT_BIT0) begin
                fs_nxt = hold_full;
              end
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_link_tx_sched.sv
// Scoreboarded bench: accepted words are queued with their accept time; a link
// receiver model decodes sclk/sd/fs and checks data, id, fs and slot cadence.
module tb_link_tx_sched;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned CLK_DIV = 2;
  localparam longint      TCLK    = 10;
  localparam longint      SLOT_T  = 2 * CLK_DIV * TCLK;

  logic                 i_clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     i_req_vld = '0;
  logic [16*N_REQ-1:0]  i_req_data = '0;
  logic [N_REQ-1:0]     o_req_rdy;
  logic                 o_sclk, o_fs, o_sd, o_busy;
  logic [3:0]           o_cur_id;

  link_tx_sched #(.N_REQ(N_REQ), .CLK_DIV(CLK_DIV)) dut (
    .i_clk      (i_clk),
    .rst_n      (rst_n),
    .i_req_vld  (i_req_vld),
    .i_req_data (i_req_data),
    .o_req_rdy  (o_req_rdy),
    .o_sclk     (o_sclk),
    .o_fs       (o_fs),
    .o_sd       (o_sd),
    .o_busy     (o_busy),
    .o_cur_id   (o_cur_id)
  );

  always #(TCLK/2) i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] data;
    int          id;
    longint      t_acc;
  } exp_t;

  exp_t         sb[$];
  logic [15:0]  src_q[N_REQ][$];
  logic [N_REQ-1:0] acc_pending = '0;
  logic [N_REQ-1:0] prev_vld = '0;
  int           rr_ptr = 0;
  int           grant_log[$];

  // Receiver model state
  bit           rx_pad = 1'b1;
  bit           rx_after_fs = 1'b0;
  int           rx_n = 0;
  logic [15:0]  rx_word = '0;
  logic [15:0]  last_word = '0;
  longint       t_rise = 0, t_e0 = 0, t_e1 = 0, t_e16 = 0, last_lat = 0;
  int           fs_ones = 0, words_rx = 0, pads = 0;
  longint       b0_log[$];
  longint       nxt_log[$];

  task automatic send(input int k, input logic [15:0] w);
    src_q[k].push_back(w);
  endtask

  // Requester driver: holds vld while its queue has words
  initial forever begin
    @(posedge i_clk);
    #2;
    for (int k = 0; k < N_REQ; k++) begin
      if (acc_pending[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      i_req_vld[k] = (src_q[k].size() > 0);
      if (src_q[k].size() > 0) i_req_data[16*k +: 16] = src_q[k][0];
    end
    acc_pending = '0;
  end

  // Acceptance and arbitration monitor
  initial forever begin
    int exp_k;
    @(negedge i_clk);
    if (rst_n) begin
      if (o_req_rdy != '0) begin
        exp_k = -1;
        for (int i = 0; i < N_REQ; i++)
          if (exp_k < 0 && prev_vld[(rr_ptr + i) % N_REQ]) exp_k = (rr_ptr + i) % N_REQ;
        chk("rr_grant", longint'(o_req_rdy), (exp_k >= 0) ? (longint'(1) << exp_k) : 0);
        if (exp_k >= 0) begin
          rr_ptr = (exp_k + 1) % N_REQ;
          grant_log.push_back(exp_k);
        end
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (o_req_rdy[k] && i_req_vld[k] && src_q[k].size() > 0) begin
          sb.push_back('{src_q[k][0], k, longint'($time) + TCLK/2});
          acc_pending[k] = 1'b1;
        end
      end
    end
    prev_vld = i_req_vld;
  end

  initial forever begin
    @(posedge o_sclk);
    t_rise = longint'($time);
  end

  // Link receiver: samples on every sclk falling edge
  initial forever begin
    exp_t e;
    bit   exp_fs;
    @(negedge o_sclk);
    if (rst_n) begin
      if (rx_pad) begin
        chk("pad_bit", longint'(o_sd), 0);
        t_e0 = longint'($time);
        if (sb.size() > 0) last_lat = t_e0 - sb[0].t_acc;
        rx_pad = 1'b0;
        rx_after_fs = 1'b0;
        rx_n = 0;
        pads++;
      end else begin
        if (rx_n == 0) begin
          chk("slot_cadence", longint'($time) - (rx_after_fs ? t_e16 : t_e0), SLOT_T);
          t_e1 = longint'($time);
        end
        rx_word = {rx_word[14:0], o_sd};
        rx_n++;
        if (rx_n == 16) begin
          chk("word_span", longint'($time) - t_e1, 15 * SLOT_T);
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_word: got %0h expected none", rx_word);
          end else begin
            e = sb.pop_front();
            chk("word_data", rx_word, e.data);
            chk("word_id", longint'(o_cur_id), e.id);
            exp_fs = (sb.size() > 0) && (sb[0].t_acc < t_rise);
            chk("fs", longint'(o_fs), exp_fs);
          end
          b0_log.push_back(t_rise);
          nxt_log.push_back((sb.size() > 0) ? sb[0].t_acc : -1);
          if (o_fs) fs_ones++;
          last_word   = rx_word;
          words_rx++;
          t_e16       = longint'($time);
          rx_after_fs = o_fs;
          rx_pad      = !o_fs;
          rx_n        = 0;
        end
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < N_REQ; k++) src_q[k].delete();
    acc_pending = '0;
    rr_ptr = 0;
    grant_log.delete();
    rx_pad = 1'b1;
    rx_after_fs = 1'b0;
    rx_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    bit pending;
    pending = 1'b1;
    while (pending && c < 20000) begin
      @(posedge i_clk);
      #1;
      c++;
      pending = (sb.size() > 0) || o_busy || !o_sclk;
      for (int k = 0; k < N_REQ; k++) if (src_q[k].size() > 0) pending = 1'b1;
    end
    chk({name, "_drained"}, longint'(pending), 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk({name, "_parked"}, longint'({o_sclk, o_sd, o_fs, o_busy}), 4'b1000);
  endtask

  task automatic wait_rx_bits(input int n, input string name);
    int c = 0;
    while (rx_n != n && c < 5000) begin
      @(posedge i_clk);
      #1;
      c++;
    end
    chk(name, rx_n, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    do_reset();

    // Idle after reset
    for (int c = 0; c < 8; c++) begin
      repeat (5) @(posedge i_clk);
      #1;
      chk("idle_outputs", longint'({o_sclk, o_sd, o_fs, o_busy, o_req_rdy, o_cur_id}),
          longint'(1) << (N_REQ + 7));
    end

    // Isolated word from req0
    fs_ones = 0; w0 = words_rx;
    @(posedge i_clk); #1;
    send(0, 16'hA5C3);
    wait_drain("t2");
    chk("t2_word", last_word, 16'hA5C3);
    chk("t2_words", words_rx - w0, 1);
    chk("t2_first_fall_latency", last_lat, (CLK_DIV + 1) * TCLK);
    chk("t2_fs_count", fs_ones, 0);

    // Three queued words on req1: back-to-back framing
    fs_ones = 0; w0 = words_rx;
    @(posedge i_clk); #1;
    send(1, 16'h0001); send(1, 16'h8000); send(1, 16'hFFFF);
    wait_drain("t3");
    chk("t3_words", words_rx - w0, 3);
    chk("t3_fs_count", fs_ones, 2);
    chk("t3_last_word", last_word, 16'hFFFF);

    // All requesters valid: round-robin order from a fresh pointer
    do_reset();
    fs_ones = 0; w0 = words_rx;
    @(posedge i_clk); #1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N_REQ; k++) send(k, 16'($urandom));
    wait_drain("t4");
    chk("t4_words", words_rx - w0, 2 * N_REQ);
    chk("t4_fs_count", fs_ones, 2 * N_REQ - 1);
    chk("t4_grants", grant_log.size(), 2 * N_REQ);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk("t4_grant_order", grant_log[i], i % N_REQ);

    // Word accepted on the same clock as the bit-0 rise: no fs, park, pad
    do_reset();
    fs_ones = 0; w0 = words_rx; pads = 0;
    b0_log.delete(); nxt_log.delete();
    @(posedge i_clk); #1;
    send(2, 16'h1234);
    wait_rx_bits(15, "t5_reach_bit15");
    repeat (CLK_DIV - 2) begin @(posedge i_clk); #1; end
    send(3, 16'hBEEF);
    wait_drain("t5");
    chk("t5_words", words_rx - w0, 2);
    chk("t5_fs_count", fs_ones, 0);
    chk("t5_pads", pads, 2);
    if (b0_log.size() > 0)
      chk("t5_accept_on_bit0_rise", nxt_log[0], b0_log[0]);
    chk("t5_last_word", last_word, 16'hBEEF);

    // Async reset mid-word, then a clean word
    do_reset();
    @(posedge i_clk); #1;
    send(1, 16'hC0DE);
    wait_rx_bits(8, "t6_reach_slot8");
    @(posedge i_clk); #4;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", longint'({o_sclk, o_sd, o_fs, o_busy, o_req_rdy, o_cur_id}),
        longint'(1) << (N_REQ + 7));
    do_reset();
    w0 = words_rx;
    @(posedge i_clk); #1;
    send(3, 16'h5A3C);
    wait_drain("t6");
    chk("t6_words", words_rx - w0, 1);
    chk("t6_word", last_word, 16'h5A3C);

    // Randomised traffic
    do_reset();
    w0 = words_rx;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 40)) @(posedge i_clk);
      #1;
      send(int'($urandom_range(0, N_REQ - 1)), 16'($urandom));
    end
    wait_drain("rand");
    chk("rand_words", words_rx - w0, 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
